// File: rtl/prescaler_if.sv
// Output bundle of the prescaler: strobe and its running strobe count.
interface prescaler_if;
  logic [3:0] Qount;
  logic       strb;

  modport master (output Qount, output strb);
  modport slave  (input  Qount, input  strb);
endinterface

// File: rtl/prescaler.sv
// Clock prescaler: one-cycle strobe every DIV clocks plus a 4-bit wrapping
// strobe count (0..QMAX) used as a slow time base downstream.
module prescaler #(
  parameter int DIV  = 10,
  parameter int QMAX = 15
) (
  input  logic               clk,
  input  logic               rst,
  prescaler_if.master        bus
);

  // Reject illegal ratios at elaboration time.
  generate
    if (DIV < 1 || DIV > 65535) begin : g_bad_div
      $error("prescaler: DIV must be in 1..65535");
    end
    if (QMAX < 1 || QMAX > 15) begin : g_bad_qmax
      $error("prescaler: QMAX must be in 1..15");
    end
  endgenerate

  // Prescale counter is at least one bit so DIV=1 still has a legal vector.
  localparam int PW = (DIV <= 1) ? 1 : $clog2(DIV);
  localparam logic [PW-1:0] PTC = PW'(DIV - 1);
  localparam logic [3:0]    QTC = 4'(QMAX);

  logic [PW-1:0] pcnt;
  logic [3:0]    qount_q;
  logic          strb_q;
  logic          tc;

  assign tc = (pcnt == PTC);

  // Free-running divider, strobe and strobe count; reset wins over tc.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt    <= '0;
      strb_q  <= 1'b0;
      qount_q <= '0;
    end else begin
      pcnt   <= tc ? '0 : pcnt + 1'b1;
      strb_q <= tc;
      if (tc) qount_q <= (qount_q == QTC) ? 4'd0 : qount_q + 4'd1;
    end
  end

  assign bus.strb  = strb_q;
  assign bus.Qount = qount_q;

endmodule

// File: tb/tb_prescaler.sv
// Directed bench for prescaler: DIV=10/QMAX=15 and DIV=1/QMAX=3 instances
// share clk/rst. Expected outputs are derived from the edge count since
// reset release and queued on each edge, then popped and compared.
module tb_prescaler;

  logic clk;
  logic rst;

  prescaler_if bus_a ();
  prescaler_if bus_b ();

  prescaler #(.DIV(10), .QMAX(15)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  prescaler #(.DIV(1),  .QMAX(3))  dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  typedef struct {
    logic       sa;
    logic [3:0] qa;
    logic       sb;
    logic [3:0] qb;
  } exp_t;

  exp_t sb_q[$];

  int checks = 0;
  int errors = 0;
  int n      = 0;   // edges since release; 0 while in reset
  int cyc    = 0;
  int last_rise = -1;
  logic prev_sa = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
      $error("prescaler comparison failed: %s", tag);
    end
  endtask

  // One clock: drive rst, push expectation at the edge, compare #1 later.
  task automatic step(input logic r);
    exp_t e, g;
    rst = r;
    @(posedge clk);
    cyc++;
    if (r) n = 0; else n++;
    e.sa = (n != 0) && (n % 10 == 0);
    e.qa = 4'((n / 10) % 16);
    e.sb = (n != 0);
    e.qb = 4'(n % 4);
    sb_q.push_back(e);
    #1;
    g = sb_q.pop_front();
    chk("a_out", {bus_a.strb, bus_a.Qount}, {g.sa, g.qa});
    chk("b_out", {bus_b.strb, bus_b.Qount}, {g.sb, g.qb});
    if (r) begin
      last_rise = -1;
    end else begin
      if (prev_sa && bus_a.strb) chk("a_double_strb", 5'd1, 5'd0);
      if (!prev_sa && bus_a.strb) begin
        if (last_rise >= 0) chk("a_period", 5'(cyc - last_rise), 5'd10);
        last_rise = cyc;
      end
    end
    prev_sa = bus_a.strb;
  endtask

  initial begin
    rst = 1'b1;
    // Reset for 5 edges: all outputs zero.
    for (int i = 0; i < 5; i++) step(1'b1);
    // Free run: 20 strobes, wrap at 16th, 17th sets Qount to 1.
    for (int i = 0; i < 205; i++) begin
      step(1'b0);
      if (n == 150) chk("a_q_15th", {1'b0, bus_a.Qount}, 5'd15);
      if (n == 160) chk("a_q_wrap", {1'b0, bus_a.Qount}, 5'd0);
      if (n == 170) chk("a_q_17th", {1'b0, bus_a.Qount}, 5'd1);
    end
    // Mid-run reset 5 cycles after the 3rd strobe.
    step(1'b1);
    for (int i = 0; i < 35; i++) step(1'b0);
    chk("a_q_3", {1'b0, bus_a.Qount}, 5'd3);
    step(1'b1);
    chk("a_mid_rst", {bus_a.strb, bus_a.Qount}, 5'd0);
    for (int i = 0; i < 12; i++) begin
      step(1'b0);
      if (n == 10) chk("a_first_after_rst", {bus_a.strb, bus_a.Qount}, 5'h11);
    end
    // Reset coincident with terminal count.
    step(1'b1);
    for (int i = 0; i < 9; i++) step(1'b0);
    step(1'b1);
    chk("a_rst_at_tc", {bus_a.strb, bus_a.Qount}, 5'd0);
    // Held reset keeps everything at zero.
    step(1'b1);
    step(1'b1);
    for (int i = 0; i < 12; i++) step(1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
